// File: rtl/pc_fetch_pkg.sv
// Shared IF/ID definitions: PCSrc codes, vectors and the IF/ID bundle.
// Used by pc_fetch and the ID-stage decoder.
package pc_fetch_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;
  localparam logic [2:0] PCSRC_IRQ = 3'b100;
  localparam logic [2:0] PCSRC_EXC = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_ADDR  = 32'h8000_0004;
  localparam logic [31:0] EXC_ADDR  = 32'h8000_0008;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        pc31;
    logic        valid;
  } if_id_t;

  // Sequential fetch keeps the mode bit; only bits 30:0 advance.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select for the IF stage.
// Branch beats stall beats ID redirects beats sequential fetch.
module pc_next_mux
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = IRQ_ADDR,
  parameter logic [31:0] EXC_VEC = EXC_ADDR
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [3:0]  if_id_region,
  input  logic        if_id_valid,
  input  logic [2:0]  id_pc_src,
  input  logic [25:0] id_instr_idx,
  input  logic [31:0] id_rs_data,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        flush,
  output logic        hold
);

  always_comb begin
    next_pc = pc_plus4;
    flush   = 1'b0;
    hold    = 1'b0;
    if (ex_branch_taken) begin
      next_pc = ex_branch_target;
      flush   = 1'b1;
    end else if (stall) begin
      next_pc = pc;
      hold    = 1'b1;
    end else if (if_id_valid) begin
      case (id_pc_src)
        PCSRC_J: begin
          next_pc = {if_id_region, id_instr_idx, 2'b00};
          flush   = 1'b1;
        end
        PCSRC_JR: begin
          next_pc = id_rs_data;
          flush   = 1'b1;
        end
        PCSRC_IRQ: begin
          next_pc = IRQ_VEC;
          flush   = 1'b1;
        end
        PCSRC_EXC: begin
          next_pc = EXC_VEC;
          flush   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// IF stage: PC register, IF/ID register and IRQ sampling.
// Define IRQ_SYNC_EN for a two-flop irq_in synchronizer.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VEC,
  parameter logic [31:0] IRQ_VEC  = IRQ_ADDR,
  parameter logic [31:0] EXC_VEC  = EXC_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  id_pc_src,
  input  logic [25:0] id_instr_idx,
  input  logic [31:0] id_rs_data,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        stall,
  input  logic        irq_in,
  input  logic [31:0] instr_rdata,
  output logic [31:0] instr_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_pc31,
  output logic        if_id_valid,
  output logic        irq_sync,
  output logic        id_ex_flush
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        flush;
  logic        hold;
  if_id_t      if_id;

  assign pc_plus4 = seq_pc(pc);

  pc_next_mux #(
    .IRQ_VEC(IRQ_VEC),
    .EXC_VEC(EXC_VEC)
  ) u_mux (
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .if_id_region    (if_id.pc_plus4[31:28]),
    .if_id_valid     (if_id.valid),
    .id_pc_src       (id_pc_src),
    .id_instr_idx    (id_instr_idx),
    .id_rs_data      (id_rs_data),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .stall           (stall),
    .next_pc         (next_pc),
    .flush           (flush),
    .hold            (hold)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc             <= RESET_PC;
      if_id.instr    <= NOP_INSTR;
      if_id.pc_plus4 <= 32'h0;
      if_id.pc31     <= 1'b1;
      if_id.valid    <= 1'b0;
    end else if (!hold) begin
      pc             <= next_pc;
      if_id.instr    <= flush ? NOP_INSTR : instr_rdata;
      if_id.pc_plus4 <= pc_plus4;
      if_id.pc31     <= pc[31];
      if_id.valid    <= !flush;
    end
  end

`ifdef IRQ_SYNC_EN
  logic irq_meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_meta <= 1'b0;
      irq_sync <= 1'b0;
    end else begin
      irq_meta <= irq_in;
      irq_sync <= irq_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_sync <= 1'b0;
    end else begin
      irq_sync <= irq_in;
    end
  end
`endif

  assign instr_addr     = pc;
  assign if_id_instr    = if_id.instr;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign if_id_pc31     = if_id.pc31;
  assign if_id_valid    = if_id.valid;
  assign id_ex_flush    = ex_branch_taken;

endmodule
